execute_stage_mc: RTL and testbench
===================================

Name: execute_stage_mc

Overview:
Parametrised execute stage for the pipelined core, the successor to the fixed 16-bit single-cycle Execute block. It sits between Decode and Memory. It adds a valid/ready handshake, registered outputs and flags, branch-target/taken generation, and an iterative multi-cycle multiplier that stalls upstream. A flush input squashes in-flight work on redirects.

Parameters:
DATA_WIDTH, 16, operand/result/npc/target width
IMM_WIDTH, 7, immediate width; sign-extended to DATA_WIDTH
IDX_WIDTH, 5, destination register index width
OP_WIDTH, 5, opcode width
SHAMT_WIDTH, $clog2(DATA_WIDTH), shift-amount bits taken from reg2_data LSBs

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high
flush  in  1  squash in-flight op and pending output
in_valid  in  1  decode presents an op
in_ready  out  1  stage can accept; = (state==IDLE) & ~flush & ~reset
control_in  in  OP_WIDTH  opcode
dest_index_in  in  IDX_WIDTH  destination register index
reg1_data  in  DATA_WIDTH  operand A
reg2_data  in  DATA_WIDTH  operand B
npc  in  DATA_WIDTH  next PC of the op
immediate  in  IMM_WIDTH  signed immediate
out_valid  out  1  one-cycle pulse; result registers are valid
control_out  out  OP_WIDTH  registered opcode
dest_index_out  out  IDX_WIDTH  registered destination index
result_out  out  DATA_WIDTH  registered ALU result
target  out  DATA_WIDTH  npc + sext(immediate), registered
branch_taken  out  1  BEQ with reg1==reg2
DEST_REG_WRITE_EN  out  1  registered write enable
ZF, GF, LF  out  1 each  registered zero / signed-greater / signed-less flags

Behaviour:
- Opcodes: 0 NOP, 1 SUB A-B, 2 ADD A+B, 3 ADDI A+sext(imm), 4 AND, 5 OR, 6 XOR, 7 SLL A<<B[SHAMT-1:0], 8 SRL (logical), 9 CMP (flags only), 10 MUL (low DATA_WIDTH bits of A*B), 11 BEQ. Opcodes 12..31 behave as NOP.
- Arithmetic is modulo 2^DATA_WIDTH. No overflow output.
- DEST_REG_WRITE_EN = 1 for opcodes 1-8 and 10. It is 0 for NOP, CMP, BEQ and undefined opcodes.
- Flags update only on SUB and CMP: ZF = (A==B), GF = signed(A)>signed(B), LF = signed(A)<signed(B). All other ops hold the flags.
- target updates for every accepted op. branch_taken = 1 only for BEQ with A==B; otherwise 0.
- Accept occurs when in_valid & in_ready at a clk edge.
- Single-cycle ops: result, control, index, write-enable and target registered at the accepting edge. out_valid = 1 for exactly the following cycle. Back-to-back accepts give a continuous out_valid.
- FSM states IDLE and MUL_BUSY.
  - IDLE: accepting MUL latches operands, a counter = DATA_WIDTH and the accumulator = 0, then goes to MUL_BUSY. out_valid is not asserted for a MUL at the accept edge.
  - MUL_BUSY: one shift-add iteration per cycle; in_ready = 0. When the counter reaches 0, the edge registers the product with out_valid = 1 and returns to IDLE. An op accepted at edge N produces out_valid in cycle N+DATA_WIDTH+1, which is DATA_WIDTH cycles after the single-cycle case.
- Upstream must hold inputs while in_ready = 0. The stage does not sample control_in during MUL_BUSY.
- Flush (synchronous): the next edge clears out_valid, DEST_REG_WRITE_EN and branch_taken, and the state goes to IDLE. Flags, result and target hold. Flush with in_valid in the same cycle: flush wins and the op is not accepted. Flush on the MUL completion edge: the product is dropped.
- Reset (asynchronous) clears, immediately: all outputs to 0, state IDLE, counter and accumulator 0. in_ready = 0 while reset is asserted. Reset mid-MUL discards the MUL with no out_valid.
- No downstream backpressure: Memory always consumes out_valid.

Test Plan:
1. SUB A=10, B=3, dest=2 -> next cycle: out_valid=1, result_out=7, DEST_REG_WRITE_EN=1, dest_index_out=2, ZF=0 GF=1 LF=0.
2. ADDI A=10, imm=7'h7F (-1) -> result_out=9. Then ADD 0xFFFF+1 -> result_out=0x0000 with flags unchanged.
3. CMP 3,3 -> ZF=1, DEST_REG_WRITE_EN=0. Then SUB 3-10 -> result_out=0xFFF9, LF=1, ZF=0. Then BEQ A=B=5, npc=0x0040, imm=7'h7C -> target=0x003C, branch_taken=1.
4. MUL 300*300 with an ADD 1+1 held behind it -> in_ready=0 for 16 cycles. out_valid then shows result_out=0x5F90. The ADD is accepted next and gives result_out=2 one cycle later.
5. MUL accepted, flush asserted 5 cycles later -> no out_valid for the MUL, in_ready=1 the cycle after the flush, flags unchanged.
6. Assert reset mid-MUL, between edges -> all outputs 0 immediately. After release, SUB 10-3 -> 7 with normal latency.

Source files
------------

// File: rtl/execute_stage_mc.sv
// Execute stage: single-cycle ALU ops, branch target/taken, and an iterative
// shift-add multiplier that holds off Decode while it runs.
module execute_stage_mc #(
  parameter int DATA_WIDTH  = 16,
  parameter int IMM_WIDTH   = 7,
  parameter int IDX_WIDTH   = 5,
  parameter int OP_WIDTH    = 5,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   control_in,
  input  logic [IDX_WIDTH-1:0]  dest_index_in,
  input  logic [DATA_WIDTH-1:0] reg1_data,
  input  logic [DATA_WIDTH-1:0] reg2_data,
  input  logic [DATA_WIDTH-1:0] npc,
  input  logic [IMM_WIDTH-1:0]  immediate,
  output logic                  out_valid,
  output logic [OP_WIDTH-1:0]   control_out,
  output logic [IDX_WIDTH-1:0]  dest_index_out,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic [DATA_WIDTH-1:0] target,
  output logic                  branch_taken,
  output logic                  DEST_REG_WRITE_EN,
  output logic                  ZF,
  output logic                  GF,
  output logic                  LF
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] OP_ADDI = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] OP_SLL  = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] OP_SRL  = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] OP_CMP  = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(10);
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = OP_WIDTH'(11);

  typedef enum logic {IDLE, MUL_BUSY} state_t;
  state_t state, state_nxt;

  logic                  accept;
  logic [DATA_WIDTH-1:0] imm_ext;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_wen;
  logic                  set_flags;
  logic [DATA_WIDTH-1:0] mul_a, mul_b, mul_acc, mul_acc_nxt;
  logic [CNT_W-1:0]      mul_cnt;
  logic [OP_WIDTH-1:0]   mul_ctrl;
  logic [IDX_WIDTH-1:0]  mul_dest;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign in_ready  = (state == IDLE) & ~flush & ~reset;
  assign accept    = in_valid & in_ready;
  assign imm_ext   = {{(DATA_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
  assign shamt     = reg2_data[SHAMT_WIDTH-1:0];
  assign set_flags = (control_in == OP_SUB) | (control_in == OP_CMP);
  assign mul_acc_nxt = mul_acc + (mul_b[0] ? mul_a : '0);

  always_comb begin
    alu_res = '0;
    alu_wen = 1'b1;
    case (control_in)
      OP_SUB:  alu_res = reg1_data - reg2_data;
      OP_ADD:  alu_res = reg1_data + reg2_data;
      OP_ADDI: alu_res = reg1_data + imm_ext;
      OP_AND:  alu_res = reg1_data & reg2_data;
      OP_OR:   alu_res = reg1_data | reg2_data;
      OP_XOR:  alu_res = reg1_data ^ reg2_data;
      OP_SLL:  alu_res = reg1_data << shamt;
      OP_SRL:  alu_res = reg1_data >> shamt;
      default: alu_wen = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept && control_in == OP_MUL) state_nxt = MUL_BUSY;
      MUL_BUSY: if (mul_cnt == CNT_W'(1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid         <= 1'b0;
      control_out       <= '0;
      dest_index_out    <= '0;
      result_out        <= '0;
      target            <= '0;
      branch_taken      <= 1'b0;
      DEST_REG_WRITE_EN <= 1'b0;
      ZF                <= 1'b0;
      GF                <= 1'b0;
      LF                <= 1'b0;
      mul_a             <= '0;
      mul_b             <= '0;
      mul_acc           <= '0;
      mul_cnt           <= '0;
      mul_ctrl          <= '0;
      mul_dest          <= '0;
    end else begin
      out_valid <= 1'b0;
      if (flush) begin
        DEST_REG_WRITE_EN <= 1'b0;
        branch_taken      <= 1'b0;
      end else if (accept) begin
        target       <= npc + imm_ext;
        branch_taken <= (control_in == OP_BEQ) && (reg1_data == reg2_data);
        if (control_in == OP_MUL) begin
          // Product is delivered later; the op itself produces no pulse yet.
          mul_a             <= reg1_data;
          mul_b             <= reg2_data;
          mul_acc           <= '0;
          mul_cnt           <= CNT_W'(DATA_WIDTH);
          mul_ctrl          <= control_in;
          mul_dest          <= dest_index_in;
          DEST_REG_WRITE_EN <= 1'b0;
        end else begin
          out_valid         <= 1'b1;
          control_out       <= control_in;
          dest_index_out    <= dest_index_in;
          result_out        <= alu_res;
          DEST_REG_WRITE_EN <= alu_wen;
          if (set_flags) begin
            ZF <= reg1_data == reg2_data;
            GF <= $signed(reg1_data) > $signed(reg2_data);
            LF <= $signed(reg1_data) < $signed(reg2_data);
          end
        end
      end else if (state == MUL_BUSY) begin
        mul_acc <= mul_acc_nxt;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt - CNT_W'(1);
        // Last iteration: publish the finished product on this same edge.
        if (mul_cnt == CNT_W'(1)) begin
          out_valid         <= 1'b1;
          result_out        <= mul_acc_nxt;
          control_out       <= mul_ctrl;
          dest_index_out    <= mul_dest;
          DEST_REG_WRITE_EN <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomised self-checking bench for execute_stage_mc against an
// arithmetic reference model of the opcode table.
module tb_execute_stage_mc;
  localparam int DW = 16, IW = 7, XW = 5, OW = 5;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready;
  logic [OW-1:0] control_in, control_out;
  logic [XW-1:0] dest_index_in, dest_index_out;
  logic [DW-1:0] reg1_data, reg2_data, npc, result_out, target;
  logic [IW-1:0] immediate;
  logic          out_valid, branch_taken, DEST_REG_WRITE_EN, ZF, GF, LF;

  int checks = 0, errors = 0;
  logic mzf = 1'b0, mgf = 1'b0, mlf = 1'b0;

  always #5 clk = ~clk;

  execute_stage_mc #(.DATA_WIDTH(DW), .IMM_WIDTH(IW), .IDX_WIDTH(XW), .OP_WIDTH(OW)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .dest_index_in(dest_index_in), .reg1_data(reg1_data),
    .reg2_data(reg2_data), .npc(npc), .immediate(immediate), .out_valid(out_valid),
    .control_out(control_out), .dest_index_out(dest_index_out), .result_out(result_out),
    .target(target), .branch_taken(branch_taken), .DEST_REG_WRITE_EN(DEST_REG_WRITE_EN),
    .ZF(ZF), .GF(GF), .LF(LF)
  );

  function automatic logic [DW-1:0] sext(input logic [IW-1:0] i);
    return {{(DW-IW){i[IW-1]}}, i};
  endfunction

  function automatic logic [DW-1:0] m_res(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic [IW-1:0] imm);
    logic [2*DW-1:0] p;
    p = a * b;
    case (op)
      1: return a - b;
      2: return a + b;
      3: return a + sext(imm);
      4: return a & b;
      5: return a | b;
      6: return a ^ b;
      7: return a << b[3:0];
      8: return a >> b[3:0];
      10: return p[DW-1:0];
      default: return '0;
    endcase
  endfunction

  function automatic logic m_wen(input logic [OW-1:0] op);
    return (op >= 1 && op <= 8) || op == 10;
  endfunction

  task automatic mdl_flags(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (op == 1 || op == 9) begin
      mzf = (a == b);
      mgf = $signed(a) > $signed(b);
      mlf = $signed(a) < $signed(b);
    end
  endtask

  task automatic drive(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] pc, input logic [IW-1:0] imm, input logic [XW-1:0] dst);
    control_in = op; reg1_data = a; reg2_data = b; npc = pc; immediate = imm;
    dest_index_in = dst; in_valid = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0); in_valid = 1'b0;
    repeat (3) tick;
    checks++;
    if ({out_valid, control_out, dest_index_out, result_out, target, branch_taken,
         DEST_REG_WRITE_EN, ZF, GF, LF, in_ready} !== '0) begin
      errors++; $display("FAIL reset_state: ov=%b res=%h tgt=%h rdy=%b", out_valid, result_out, target, in_ready);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_basic;
    @(negedge clk);
    drive(1, 10, 3, 16'h0010, 7'h01, 2); tick; mdl_flags(1, 10, 3);
    checks++;
    if ({out_valid, result_out, DEST_REG_WRITE_EN, dest_index_out, ZF, GF, LF} !==
        {1'b1, 16'd7, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL sub_basic: ov=%b res=%h we=%b dst=%0d z%b g%b l%b exp 1/0007/1/2/010",
                         out_valid, result_out, DEST_REG_WRITE_EN, dest_index_out, ZF, GF, LF);
    end
    drive(3, 10, 0, 0, 7'h7F, 3); tick;
    checks++;
    if (result_out !== 16'd9 || out_valid !== 1'b1) begin
      errors++; $display("FAIL addi_neg: got %h exp 0009", result_out);
    end
    drive(2, 16'hFFFF, 1, 0, 0, 4); tick;
    checks++;
    if ({result_out, ZF, GF, LF} !== {16'h0000, mzf, mgf, mlf}) begin
      errors++; $display("FAIL add_wrap: res=%h flags=%b%b%b exp 0000 %b%b%b", result_out, ZF, GF, LF, mzf, mgf, mlf);
    end
    drive(9, 3, 3, 0, 0, 5); tick; mdl_flags(9, 3, 3);
    checks++;
    if ({ZF, GF, LF, DEST_REG_WRITE_EN} !== 4'b1000) begin
      errors++; $display("FAIL cmp_eq: zgl_we=%b%b%b%b exp 1000", ZF, GF, LF, DEST_REG_WRITE_EN);
    end
    drive(1, 3, 10, 0, 0, 6); tick; mdl_flags(1, 3, 10);
    checks++;
    if ({result_out, ZF, LF} !== {16'hFFF9, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sub_neg: res=%h z=%b l=%b exp FFF9 0 1", result_out, ZF, LF);
    end
    drive(11, 5, 5, 16'h0040, 7'h7C, 7); tick;
    checks++;
    if ({target, branch_taken, DEST_REG_WRITE_EN} !== {16'h003C, 1'b1, 1'b0}) begin
      errors++; $display("FAIL beq_taken: tgt=%h bt=%b we=%b exp 003C 1 0", target, branch_taken, DEST_REG_WRITE_EN);
    end
    in_valid = 1'b0; tick;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_no_valid: got %b exp 0", out_valid); end
  endtask

  task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] pc,
                         input logic [IW-1:0] imm, input logic [XW-1:0] dst, input bit hold_add);
    int n, busy;
    logic [DW-1:0] exp_p, exp_t;
    exp_p = m_res(10, a, b, 0); exp_t = pc + sext(imm);
    drive(10, a, b, pc, imm, dst);
    tick;
    n = 0; busy = 0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_accept_no_valid: got %b exp 0", out_valid); end
    if (hold_add) drive(2, 1, 1, 0, 0, 9); else in_valid = 1'b0;
    if (!in_ready) busy++;
    while (!out_valid && n < 40) begin
      tick; n++;
      if (!out_valid && !in_ready) busy++;
    end
    checks++;
    if (n !== DW || busy !== DW) begin
      errors++; $display("FAIL mul_latency: cycles=%0d busy=%0d exp %0d", n, busy, DW);
    end
    checks++;
    if ({out_valid, result_out, DEST_REG_WRITE_EN, control_out, dest_index_out, target, ZF, GF, LF} !==
        {1'b1, exp_p, 1'b1, 5'd10, dst, exp_t, mzf, mgf, mlf}) begin
      errors++; $display("FAIL mul_result: ov=%b res=%h we=%b op=%0d dst=%0d tgt=%h exp res=%h dst=%0d tgt=%h",
                         out_valid, result_out, DEST_REG_WRITE_EN, control_out, dest_index_out, target, exp_p, dst, exp_t);
    end
    if (hold_add) begin
      tick;
      checks++;
      if ({out_valid, result_out, dest_index_out} !== {1'b1, 16'd2, 5'd9}) begin
        errors++; $display("FAIL mul_held_add: ov=%b res=%h dst=%0d exp 1 0002 9", out_valid, result_out, dest_index_out);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mul;
    run_mul(16'd300, 16'd300, 16'h0100, 7'h02, 8, 1'b1);
    for (int i = 0; i < 5; i++)
      run_mul(DW'($urandom), DW'($urandom), DW'($urandom), IW'($urandom), XW'($urandom), 1'b0);
  endtask

  task automatic test_random_b2b;
    logic [OW-1:0] op;
    logic [DW-1:0] a, b, pc, er;
    logic [IW-1:0] imm;
    logic [XW-1:0] dst;
    for (int i = 0; i < 80; i++) begin
      op = OW'($urandom_range(0, 31));
      if (op == 10) op = 1;
      a = DW'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : DW'($urandom);
      pc = DW'($urandom); imm = IW'($urandom); dst = XW'($urandom);
      drive(op, a, b, pc, imm, dst);
      tick;
      mdl_flags(op, a, b);
      er = m_res(op, a, b, imm);
      checks++;
      if ({out_valid, control_out, dest_index_out, DEST_REG_WRITE_EN, branch_taken, target} !==
          {1'b1, op, dst, m_wen(op), (op == 11 && a == b), pc + sext(imm)}) begin
        errors++; $display("FAIL rand_ctrl op=%0d: ov=%b op=%0d dst=%0d we=%b bt=%b tgt=%h exp dst=%0d we=%b tgt=%h",
                           op, out_valid, control_out, dest_index_out, DEST_REG_WRITE_EN, branch_taken, target,
                           dst, m_wen(op), pc + sext(imm));
      end
      checks++;
      if ({ZF, GF, LF} !== {mzf, mgf, mlf}) begin
        errors++; $display("FAIL rand_flags op=%0d: got %b%b%b exp %b%b%b", op, ZF, GF, LF, mzf, mgf, mlf);
      end
      if (m_wen(op)) begin
        checks++;
        if (result_out !== er) begin
          errors++; $display("FAIL rand_result op=%0d a=%h b=%h: got %h exp %h", op, a, b, result_out, er);
        end
      end
    end
    in_valid = 1'b0;
    tick;
  endtask

  task automatic test_flush;
    int seen;
    logic [DW-1:0] res_hold;
    res_hold = result_out;
    drive(10, 16'd77, 16'd5, 0, 0, 3);
    tick;
    in_valid = 1'b0;
    repeat (4) tick;
    flush = 1'b1;
    drive(1, 9, 2, 0, 0, 4);
    tick;
    checks++;
    if ({out_valid, DEST_REG_WRITE_EN, branch_taken} !== 3'b000) begin
      errors++; $display("FAIL flush_clear: ov=%b we=%b bt=%b exp 000", out_valid, DEST_REG_WRITE_EN, branch_taken);
    end
    flush = 1'b0; in_valid = 1'b0; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b exp 1", in_ready); end
    seen = 0;
    repeat (20) begin tick; if (out_valid) seen++; end
    checks++;
    if (seen !== 0 || {ZF, GF, LF} !== {mzf, mgf, mlf} || result_out !== res_hold) begin
      errors++; $display("FAIL flush_drop: pulses=%0d flags=%b%b%b res=%h exp 0 %b%b%b %h",
                         seen, ZF, GF, LF, result_out, mzf, mgf, mlf, res_hold);
    end
  endtask

  task automatic test_reset_mid_mul;
    int seen;
    drive(10, 16'd123, 16'd45, 16'h1234, 7'h11, 6);
    tick;
    in_valid = 1'b0;
    repeat (3) tick;
    #2 reset = 1'b1; #1;
    checks++;
    if ({out_valid, control_out, dest_index_out, result_out, target, branch_taken,
         DEST_REG_WRITE_EN, ZF, GF, LF, in_ready} !== '0) begin
      errors++; $display("FAIL reset_async: ov=%b res=%h tgt=%h flags=%b%b%b rdy=%b",
                         out_valid, result_out, target, ZF, GF, LF, in_ready);
    end
    mzf = 1'b0; mgf = 1'b0; mlf = 1'b0;
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (20) begin tick; if (out_valid) seen++; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_mul_dropped: pulses=%0d exp 0", seen); end
    drive(1, 10, 3, 0, 0, 2); tick; mdl_flags(1, 10, 3);
    checks++;
    if ({out_valid, result_out, ZF, GF, LF} !== {1'b1, 16'd7, 1'b0, 1'b1, 1'b0}) begin
      errors++; $display("FAIL post_reset_sub: ov=%b res=%h flags=%b%b%b exp 1 0007 010",
                         out_valid, result_out, ZF, GF, LF);
    end
    in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mul;
    test_random_b2b;
    test_flush;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
